// File: rtl/window_diff_if.sv
// Pixel-in / difference-out bundle for window_diff.
// master: pixel source and result consumer. slave: the window_diff core.
interface window_diff_if;
   logic       en;
   logic [7:0] pix;
   logic [8:0] d1;
   logic [8:0] d2;
   logic [8:0] d3;
   logic [8:0] d4;
   logic [8:0] d5;
   logic       dv;
   logic       frame_done;

   modport master (
      output en, pix,
      input  d1, d2, d3, d4, d5, dv, frame_done
   );

   modport slave (
      input  en, pix,
      output d1, d2, d3, d4, d5, dv, frame_done
   );
endinterface

// File: rtl/window_diff.sv
// window_diff: 3x3 neighbourhood difference pre-stage for shiftscale.
// Buffers two lines of a raster pixel stream and, for every interior centre,
// emits registered C-N, C-S, C-W, C-E and C-diagonal-average differences.
// Optional feature macro: WINDOW_DIFF_DIAG_EN (diagonal average on d5;
// when undefined d5 is zero and the diagonal taps and adder are absent).
module window_diff #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128
) (
   input  logic         clk_i,
   input  logic         rst_i,
   window_diff_if.slave bus
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   // Unsigned 8-bit operands extended to 9-bit two's complement difference.
   function automatic logic [8:0] diff9(input logic [7:0] a, input logic [7:0] b);
      diff9 = {1'b0, a} - {1'b0, b};
   endfunction

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   // lb1 holds the previous line, lb2 the line before that.
   logic [7:0] lb1_q [IMG_W];
   logic [7:0] lb2_q [IMG_W];
   logic [7:0] rd1_s;
   logic [7:0] rd2_s;

   // Column-delay taps: c1/w1 = line-1 at c-1/c-2, n2 = line-2 at c-1,
   // s0 = current line at c-1.
   logic [7:0] c1_q;
   logic [7:0] w1_q;
   logic [7:0] n2_q;
   logic [7:0] s0_q;

   logic [8:0] d1_q, d2_q, d3_q, d4_q, d5_q;
   logic [8:0] d1_d, d2_d, d3_d, d4_d, d5_d;
   logic       dv_q, dv_d;
   logic       fd_q, fd_d;
   logic       fire_s;
   logic       last_s;
   logic [8:0] d5_s;

   // Old contents of the current column: the write below lands after the read.
   assign rd1_s = lb1_q[col_q];
   assign rd2_s = lb2_q[col_q];

`ifdef WINDOW_DIFF_DIAG_EN
   logic [7:0] nw2_q;
   logic [7:0] sw0_q;
   logic [9:0] sum_s;

   // Diagonal average: NW, NE from line-2, SW, SE from the current line.
   always_comb begin
      sum_s = {2'b00, nw2_q} + {2'b00, rd2_s} + {2'b00, sw0_q} + {2'b00, bus.pix};
      d5_s  = diff9(c1_q, sum_s[9:2]);
   end

   // Second-column diagonal taps, advanced only on accepted pixels.
   always_ff @(posedge clk_i) begin
      if (bus.en && !rst_i) begin
         nw2_q <= n2_q;
         sw0_q <= s0_q;
      end
   end
`else
   assign d5_s = 9'd0;
`endif

   // Raster position counters, frozen while en is low.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (bus.en) begin
         if (col_q == COL_LAST) begin
            col_d = {CW{1'b0}};
            if (row_q == ROW_LAST) begin
               row_d = {RW{1'b0}};
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
            row_d = row_q;
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   // A window completes on an accepted pixel at row >= 2 and col >= 2 only.
   assign fire_s = bus.en && (row_q >= RW'(2)) && (col_q >= CW'(2));
   assign last_s = (row_q == ROW_LAST) && (col_q == COL_LAST);

   // Next output values: fresh differences on a completed window, else hold.
   always_comb begin
      d1_d = d1_q;
      d2_d = d2_q;
      d3_d = d3_q;
      d4_d = d4_q;
      d5_d = d5_q;
      dv_d = 1'b0;
      fd_d = 1'b0;
      if (fire_s) begin
         d1_d = diff9(c1_q, n2_q);
         d2_d = diff9(c1_q, s0_q);
         d3_d = diff9(c1_q, w1_q);
         d4_d = diff9(c1_q, rd1_s);
         d5_d = d5_s;
         dv_d = 1'b1;
         fd_d = last_s;
      end else begin
         dv_d = 1'b0;
         fd_d = 1'b0;
      end
   end

   // Counter and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         col_q <= {CW{1'b0}};
         row_q <= {RW{1'b0}};
         d1_q  <= 9'd0;
         d2_q  <= 9'd0;
         d3_q  <= 9'd0;
         d4_q  <= 9'd0;
         d5_q  <= 9'd0;
         dv_q  <= 1'b0;
         fd_q  <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         d1_q  <= d1_d;
         d2_q  <= d2_d;
         d3_q  <= d3_d;
         d4_q  <= d4_d;
         d5_q  <= d5_d;
         dv_q  <= dv_d;
         fd_q  <= fd_d;
      end
   end

   // Line buffers and column taps; contents need no reset since dv masks them.
   always_ff @(posedge clk_i) begin
      if (bus.en && !rst_i) begin
         lb1_q[col_q] <= bus.pix;
         lb2_q[col_q] <= rd1_s;
         c1_q         <= rd1_s;
         w1_q         <= c1_q;
         n2_q         <= rd2_s;
         s0_q         <= bus.pix;
      end
   end

   assign bus.d1         = d1_q;
   assign bus.d2         = d2_q;
   assign bus.d3         = d3_q;
   assign bus.d4         = d4_q;
   assign bus.d5         = d5_q;
   assign bus.dv         = dv_q;
   assign bus.frame_done = fd_q;

endmodule
